// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the pipelined shifter: op codes, fill modes, bit reversal.
// Latency: n/a (package only).
// Backpressure: n/a.
package shift_pkg;

  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b101;

  // What enters the vacated top bits of each right-shift level.
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_e;

  // Widest datapath bit_reverse handles; callers zero-extend to this width,
  // reverse, and keep the top WIDTH bits (the reversed operand lands there).
  localparam int REV_MAX_W = 1024;

  function automatic logic [REV_MAX_W-1:0] bit_reverse(input logic [REV_MAX_W-1:0] v);
    return {<<{v}};
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: NUM_LVL barrel levels (starting at FIRST_LVL) feeding a register.
// Latency: 1 cycle. Ports: in_* upstream side, out_* downstream side, in_rdy = this stage loads.
// Backpressure: loads when empty or when the downstream stage loads; flush clears valid and blocks loading.
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 5,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1,
  localparam int LOG_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_res,
  input  logic [LOG_W-1:0] in_sa,
  input  fill_e            in_fill,
  input  logic             in_sign,
  input  logic             in_rev,
  input  logic             in_err,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_res,
  output logic [LOG_W-1:0] out_sa,
  output fill_e            out_fill,
  output logic             out_sign,
  output logic             out_rev,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  logic             load;
  logic [WIDTH-1:0] lvl_res;
  logic [WIDTH-1:0] fill_bits;
  logic [LOG_W-1:0] sa_v;

  logic             vld_q,  vld_d;
  logic [WIDTH-1:0] res_q,  res_d;
  logic [LOG_W-1:0] sa_q,   sa_d;
  fill_e            fill_q, fill_d;
  logic             sign_q, sign_d;
  logic             rev_q,  rev_d;
  logic             err_q,  err_d;
  logic [TAG_W-1:0] tag_q,  tag_d;

  // out_rdy is the downstream load condition, so bubbles collapse.
  assign load   = !flush && (!vld_q || out_rdy);
  assign in_rdy = load;

  // Level l shifts right by 2**(FIRST_LVL+l); sa_v walks the relevant sa bits.
  always_comb begin
    lvl_res   = in_res;
    fill_bits = '0;
    sa_v      = in_sa >> FIRST_LVL;
    for (int l = 0; l < NUM_LVL; l++) begin
      fill_bits = '0;
      case (in_fill)
        FILL_SIGN: fill_bits = {WIDTH{in_sign}} << (WIDTH - (1 << (FIRST_LVL + l)));
        FILL_ROT:  fill_bits = lvl_res << (WIDTH - (1 << (FIRST_LVL + l)));
        default:   fill_bits = '0;
      endcase
      if (sa_v[0]) begin
        lvl_res = (lvl_res >> (1 << (FIRST_LVL + l))) | fill_bits;
      end
      sa_v = sa_v >> 1;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    res_d  = res_q;
    sa_d   = sa_q;
    fill_d = fill_q;
    sign_d = sign_q;
    rev_d  = rev_q;
    err_d  = err_q;
    tag_d  = tag_q;
    if (flush) begin
      vld_d = 1'b0;                 // data registers deliberately untouched
    end else if (load) begin
      vld_d = in_vld;
      if (in_vld) begin
        res_d  = lvl_res;
        sa_d   = in_sa;
        fill_d = in_fill;
        sign_d = in_sign;
        rev_d  = in_rev;
        err_d  = in_err;
        tag_d  = in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      res_q  <= '0;
      sa_q   <= '0;
      fill_q <= FILL_ZERO;
      sign_q <= 1'b0;
      rev_q  <= 1'b0;
      err_q  <= 1'b0;
      tag_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      sa_q   <= sa_d;
      fill_q <= fill_d;
      sign_q <= sign_d;
      rev_q  <= rev_d;
      err_q  <= err_d;
      tag_q  <= tag_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_res  = res_q;
  assign out_sa   = sa_q;
  assign out_fill = fill_q;
  assign out_sign = sign_q;
  assign out_rev  = rev_q;
  assign out_err  = err_q;
  assign out_tag  = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shifter/rotator (SRL/SRA/SLL/ROTR/ROTL) with tag passthrough and illegal-op flag.
// Latency: STAGES cycles accept-to-out_valid, 1 result/cycle. Ports: in_* request, out_* result, flush, busy.
// Backpressure: valid/ready; last stage holds while out_valid && !out_ready, in_ready drops when full or flushing.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  localparam int LOG_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic [LOG_W-1:0] in_sa,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int PER = (LOG_W + STAGES - 1) / STAGES;   // levels per stage, rounded up

  // Index k is the input of stage k; index STAGES is the last stage's register.
  logic [STAGES:0]  s_vld;
  logic [STAGES:0]  s_load;
  logic [WIDTH-1:0] s_res  [STAGES+1];
  logic [LOG_W-1:0] s_sa   [STAGES+1];
  fill_e            s_fill [STAGES+1];
  logic [STAGES:0]  s_sign;
  logic [STAGES:0]  s_rev;
  logic [STAGES:0]  s_err;
  logic [TAG_W-1:0] s_tag  [STAGES+1];

  fill_e            dec_fill;
  logic             dec_rev;
  logic             dec_err;
  logic [LOG_W-1:0] dec_sa;

  // Left ops become right ops on a reversed operand; illegal ops pass through with sa forced to 0.
  always_comb begin
    dec_fill = FILL_ZERO;
    dec_rev  = 1'b0;
    dec_err  = 1'b0;
    dec_sa   = in_sa;
    case (in_op)
      OP_SRL:  dec_fill = FILL_ZERO;
      OP_SRA:  dec_fill = FILL_SIGN;
      OP_SLL:  dec_rev  = 1'b1;
      OP_ROTR: dec_fill = FILL_ROT;
      OP_ROTL: begin
        dec_fill = FILL_ROT;
        dec_rev  = 1'b1;
      end
      default: begin
        dec_err = 1'b1;
        dec_sa  = '0;
      end
    endcase
  end

  assign s_vld[0]  = in_valid;
  assign s_res[0]  = dec_rev ? WIDTH'(bit_reverse(REV_MAX_W'(in_d)) >> (REV_MAX_W - WIDTH)) : in_d;
  assign s_sa[0]   = dec_sa;
  assign s_fill[0] = dec_fill;
  assign s_sign[0] = in_d[WIDTH-1];
  assign s_rev[0]  = dec_rev;
  assign s_err[0]  = dec_err;
  assign s_tag[0]  = in_tag;

  assign s_load[STAGES] = out_ready;
  assign in_ready       = s_load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = (k * PER < LOG_W) ? k * PER : LOG_W;
    localparam int NUM   = (k == STAGES - 1) ? (LOG_W - FIRST)
                         : ((LOG_W - FIRST < PER) ? (LOG_W - FIRST) : PER);
    shift_pipe_stage #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .FIRST_LVL (FIRST),
      .NUM_LVL   (NUM)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_vld   (s_vld[k]),
      .in_rdy   (s_load[k]),
      .in_res   (s_res[k]),
      .in_sa    (s_sa[k]),
      .in_fill  (s_fill[k]),
      .in_sign  (s_sign[k]),
      .in_rev   (s_rev[k]),
      .in_err   (s_err[k]),
      .in_tag   (s_tag[k]),
      .out_vld  (s_vld[k+1]),
      .out_rdy  (s_load[k+1]),
      .out_res  (s_res[k+1]),
      .out_sa   (s_sa[k+1]),
      .out_fill (s_fill[k+1]),
      .out_sign (s_sign[k+1]),
      .out_rev  (s_rev[k+1]),
      .out_err  (s_err[k+1]),
      .out_tag  (s_tag[k+1])
    );
  end

  // The last stage register is the output register; only the undo-reversal sits after it.
  assign out_valid = s_vld[STAGES];
  assign out_res   = s_rev[STAGES]
                   ? WIDTH'(bit_reverse(REV_MAX_W'(s_res[STAGES])) >> (REV_MAX_W - WIDTH))
                   : s_res[STAGES];
  assign out_tag   = s_tag[STAGES];
  assign out_err   = s_err[STAGES];
  assign busy      = |s_vld[STAGES:1];

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic [4:0]  in_sa;
  logic [2:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;
  logic        out_err;
  logic        busy;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .in_sa     (in_sa),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int          acc;
    bit          lat;
    bit          seq;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  sa;
    logic [31:0] res;
    logic        err;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: peeks during stalls, pops on every output handshake.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          if (out_ready) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual tag=%0d res=%h expected none", out_tag, out_res);
          end
        end else if (!out_ready) begin
          chk("stall_res", out_res, q[0].res);
          chk("stall_tag", 32'(out_tag), 32'(q[0].tag));
        end else begin
          e = q.pop_front();
          chk("res", out_res, e.res);
          chk("tag", 32'(out_tag), 32'(e.tag));
          chk("err", 32'(out_err), 32'(e.err));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          if (e.seq) chk("spacing", 32'(cyc - last_out), 32'd1);
          last_out = cyc;
        end
      end
    end
  end

  // Called right after a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sa,
                      input logic [4:0] tag, input logic [31:0] r, input logic er,
                      input bit lat, input bit seq, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_d     = d;
    in_sa    = sa;
    in_tag   = tag;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual in_ready=0 expected 1 (tag %0d)", tag);
    end else if (push) begin
      q.push_back('{res: r, tag: tag, err: er, acc: cyc, lat: lat, seq: seq});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_d = '0; in_sa = '0; in_op = '0; in_tag = '0;

    // Hand-computed vectors: op, d, sa, expected result, expected err.
    vecs.push_back('{3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0}); // SRA
    vecs.push_back('{3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0}); // SRL
    vecs.push_back('{3'b011, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0}); // ROTR
    vecs.push_back('{3'b101, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0}); // ROTL
    vecs.push_back('{3'b100, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0}); // SLL
    vecs.push_back('{3'b100, 32'h1234_5678, 5'd8,  32'h3456_7800, 1'b0}); // SLL
    vecs.push_back('{3'b010, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0}); // SRA positive
    vecs.push_back('{3'b001, 32'hA5C3_0F81, 5'd0,  32'hA5C3_0F81, 1'b0}); // sa=0 x5
    vecs.push_back('{3'b010, 32'hA5C3_0F81, 5'd0,  32'hA5C3_0F81, 1'b0});
    vecs.push_back('{3'b100, 32'hA5C3_0F81, 5'd0,  32'hA5C3_0F81, 1'b0});
    vecs.push_back('{3'b011, 32'hA5C3_0F81, 5'd0,  32'hA5C3_0F81, 1'b0});
    vecs.push_back('{3'b101, 32'hA5C3_0F81, 5'd0,  32'hA5C3_0F81, 1'b0});
    vecs.push_back('{3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0}); // sa=31
    vecs.push_back('{3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{3'b011, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0});
    vecs.push_back('{3'b101, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0});
    vecs.push_back('{3'b111, 32'h1234_5678, 5'd8,  32'h1234_5678, 1'b1}); // illegal
    vecs.push_back('{3'b000, 32'hDEAD_BEEF, 5'd3,  32'hDEAD_BEEF, 1'b1});
    vecs.push_back('{3'b110, 32'h0F0F_0F0F, 5'd17, 32'h0F0F_0F0F, 1'b1});

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Back-to-back directed vectors, latency checked on each.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].op, vecs[i].d, vecs[i].sa, 5'(i), vecs[i].res, vecs[i].err, 1'b1, 1'b0, 1'b1);
    end
    idle();
    drain();

    // Backpressure: two accepts fill the pipe, third waits for out_ready.
    @(negedge clk);
    out_ready = 1'b0;
    send(3'b001, 32'h0000_0010, 5'd4, 5'd1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    send(3'b100, 32'h0000_0001, 5'd2, 5'd2, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    fork
      send(3'b011, 32'h0000_0003, 5'd1, 5'd3, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Flush with two in flight and a request presented on the flush edge.
    @(negedge clk);
    out_ready = 1'b0;
    send(3'b001, 32'h0000_00FF, 5'd1, 5'd9,  32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(3'b001, 32'h0000_0FFF, 5'd1, 5'd10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_d = 32'h5555_5555; in_tag = 5'd11;
    flush = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    idle();
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    send(3'b010, 32'hF000_0000, 5'd8, 5'd12, 32'hFFF0_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

    // Asynchronous reset mid-stream.
    @(negedge clk);
    out_ready = 1'b0;
    send(3'b001, 32'h1111_1111, 5'd1, 5'd20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(3'b001, 32'h2222_2222, 5'd1, 5'd21, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    #1 chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("rerst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("no_stale_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    send(3'b101, 32'h0000_00F0, 5'd28, 5'd22, 32'h0000_000F, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
